mux_sel_pipe: RTL and testbench

Parametrised N-way, WIDTH-bit selector with a registered output and a valid/ready handshake on both sides. It is the pipelined successor of the team's fixed 4-input, 32-bit gate-level multiplexer. It sits between datapath stages, for example writeback or forwarding select, where the downstream stage can stall. A 2-entry skid buffer keeps full throughput, keeps in_ready registered, and flags out-of-range selects.

---
 rtl/mux_sel_pipe_pkg.sv | 24 ++
 rtl/mux_sel_pipe_comb.sv | 35 +++
 rtl/mux_sel_pipe.sv | 163 ++++++++++++++++
 tb/tb_mux_sel_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe_pkg
// Shared definitions for the pipelined N-way selector:
//   - sel_width(): select-field width for a given channel count (ceil log2,
//     never less than 1)
//   - buf_state_e: occupancy of the 2-entry output/skid buffer. The encoding
//     is {out_valid, skid_valid}, so the state register doubles as both flags.
// -----------------------------------------------------------------------------
package mux_sel_pipe_pkg;

    function automatic int sel_width(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } buf_state_e;

endpackage

// File: rtl/mux_sel_pipe_comb.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe_comb
// Purely combinational N:1 selector with out-of-range detection.
// Ports:
//   in_data  [NUM_IN*WIDTH] channel k at bits [k*WIDTH +: WIDTH]
//   in_sel   [SEL_W]        channel select
//   out_data [WIDTH]        selected channel, or 0 when in_sel >= NUM_IN
//   out_err  [1]            in_sel >= NUM_IN
// -----------------------------------------------------------------------------
module mux_sel_comb
    import mux_sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err
);

    // Any select that matches no channel falls through to zero data + err.
    always_comb begin
        out_data = '0;
        out_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
                out_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// -----------------------------------------------------------------------------
// mux_sel_pipe
// N-way, WIDTH-bit selector with registered output, valid/ready on both sides
// and a 2-entry skid buffer so in_ready is a flop and throughput stays at one
// word per cycle. Out-of-range selects produce a zero word flagged with
// out_err and bump a saturating error counter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_sel        upstream word and channel select
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   out_data/out_sel/out_err  selected word, its select, out-of-range flag
//   out_valid/out_ready   downstream handshake
//   err_cnt, err_clr      saturating out-of-range count, synchronous clear
// -----------------------------------------------------------------------------
module mux_sel_pipe
    import mux_sel_pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        err_cnt,
    input  logic                    err_clr
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (sel_data),
        .out_err  (sel_err)
    );

    buf_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = sel_data;
                    main_sel_d  = in_sel;
                    main_err_d  = sel_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_data_d = sel_data;
                    main_sel_d  = in_sel;
                    main_err_d  = sel_err;
                end else if (accept) begin
                    // Downstream stalled: park the new word behind the held one.
                    skid_data_d = sel_data;
                    skid_sel_d  = in_sel;
                    skid_err_d  = sel_err;
                    state_d     = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can move the buffer.
                if (pop) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Registered ready: looks at the next occupancy, never at out_ready.
        in_ready_d = (state_d != ST_TWO);

        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept && sel_err) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;
    assign out_sel  = main_sel_q;
    assign out_err  = main_err_q;
    assign err_cnt  = err_cnt_q;

    // Upstream must hold a refused word unchanged until it is accepted.
    a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready_q) |=> (in_valid && $stable(in_data) && $stable(in_sel)));

endmodule

// File: tb/tb_mux_sel_pipe.sv
module tb_mux_sel_pipe;

    localparam int NW    = 10000;
    localparam int LIMIT = 60000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: default 4 x 32, 16-bit counter
    logic [127:0] a_in_data;
    logic [1:0]   a_in_sel;
    logic         a_in_valid, a_in_ready;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;
    logic         a_out_err, a_out_valid, a_out_ready;
    logic [15:0]  a_err_cnt;
    logic         a_err_clr;

    // Instance B: 3 x 8, 2-bit counter (has an unused select code)
    logic [23:0]  b_in_data;
    logic [1:0]   b_in_sel;
    logic         b_in_valid, b_in_ready;
    logic [7:0]   b_out_data;
    logic [1:0]   b_out_sel;
    logic         b_out_err, b_out_valid, b_out_ready;
    logic [1:0]   b_err_cnt;
    logic         b_err_clr;

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_err(a_out_err),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_cnt(a_err_cnt), .err_clr(a_err_clr)
    );

    mux_sel_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_err(b_out_err),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_cnt(b_err_cnt), .err_clr(b_err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: channel s of a 4x32 bundle, packed as {err, sel, data}.
    function automatic logic [34:0] model_a(input logic [127:0] d, input logic [1:0] s);
        int idx;
        idx = int'(s);
        if (idx < 4) return {1'b0, s, 32'(d >> (32 * idx))};
        return {1'b1, s, 32'h0};
    endfunction

    logic [31:0] ch [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    typedef logic [34:0] word_t;
    word_t q[$];
    word_t exp_w, held_w;
    bit acc, pop, stall;
    int accepted, popped, cycles;

    initial begin
        a_in_data = '0; a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_err_clr = 1'b0;
        b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_err_clr = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_sel_err", {a_out_sel, a_out_err}, 0);
        chk("rst_err_cnt", a_err_cnt, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word, 1-cycle latency
        a_in_data = {ch[3], ch[2], ch[1], ch[0]};
        a_in_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        chk("t1_valid", a_out_valid, 1);
        chk("t1_data", a_out_data, 32'h33333333);
        chk("t1_sel", a_out_sel, 2);
        chk("t1_err", a_out_err, 0);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            a_in_sel = 2'(i);
            step();
            chk("t2_data", a_out_data, ch[i]);
            chk("t2_sel", a_out_sel, i);
            chk("t2_in_ready", a_in_ready, 1);
        end
        a_in_valid = 1'b0;
        step();
        chk("t2_drained", a_out_valid, 0);

        // Stall fills the skid, then drain in order
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd0;
        step();
        chk("t3_ready_one", a_in_ready, 1);
        a_in_sel = 2'd1;
        step();
        a_in_valid = 1'b0;
        chk("t3_ready_two", a_in_ready, 0);
        chk("t3_hold_first", a_out_data, 32'h11111111);
        step();
        chk("t3_still_held", a_out_data, 32'h11111111);
        chk("t3_still_full", a_in_ready, 0);
        a_out_ready = 1'b1;
        step();
        chk("t3_second", a_out_data, 32'h22222222);
        chk("t3_ready_back", a_in_ready, 1);
        chk("t3_valid2", a_out_valid, 1);
        step();
        chk("t3_empty", a_out_valid, 0);

        // Out-of-range selects and counter saturation (NUM_IN=3, CNT_W=2)
        b_in_data = {8'h33, 8'h22, 8'h11};
        b_in_sel = 2'd3; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        chk("t4_bad_data", b_out_data, 0);
        chk("t4_bad_err", b_out_err, 1);
        chk("t4_bad_sel", b_out_sel, 3);
        chk("t4_cnt1", b_err_cnt, 1);
        repeat (4) step();
        chk("t4_cnt_sat", b_err_cnt, 3);
        b_err_clr = 1'b1;
        step();
        chk("t4_clr_prio", b_err_cnt, 0);
        b_err_clr = 1'b0; b_in_sel = 2'd1;
        step();
        chk("t4_good_data", b_out_data, 8'h22);
        chk("t4_good_err", b_out_err, 0);
        chk("t4_good_cnt", b_err_cnt, 0);
        b_in_valid = 1'b0;

        // Asynchronous reset while both entries are full
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd2;
        step();
        a_in_sel = 2'd3;
        step();
        a_in_valid = 1'b0;
        chk("t5_full", a_in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", a_out_valid, 0);
        chk("t5_async_ready", a_in_ready, 1);
        chk("t5_async_data", a_out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_in_sel = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        chk("t5_new_data", a_out_data, 32'h22222222);
        chk("t5_new_sel", a_out_sel, 1);
        a_in_valid = 1'b0;
        step();
        chk("t5_no_stale", a_out_valid, 0);

        // Randomised handshake against a queue model
        accepted = 0; popped = 0; cycles = 0;
        a_out_ready = 1'b0;
        while (popped < NW && cycles < LIMIT) begin
            acc = a_in_valid && a_in_ready;
            pop = a_out_valid && a_out_ready;
            if (pop) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_word", popped + 1, accepted);
                end else begin
                    exp_w = q.pop_front();
                    chk("rnd_word", {a_out_err, a_out_sel, a_out_data}, exp_w);
                end
                popped++;
            end
            if (acc) begin
                q.push_back(model_a(a_in_data, a_in_sel));
                accepted++;
            end
            stall = a_out_valid && !a_out_ready;
            held_w = {a_out_err, a_out_sel, a_out_data};
            step();
            cycles++;
            if (stall) chk("rnd_hold", {a_out_err, a_out_sel, a_out_data}, held_w);
            if (acc || !a_in_valid) begin
                if (accepted < NW && $urandom_range(1, 0) == 1) begin
                    a_in_valid = 1'b1;
                    a_in_data = {$urandom, $urandom, $urandom, $urandom};
                    a_in_sel = 2'($urandom_range(3, 0));
                end else begin
                    a_in_valid = 1'b0;
                end
            end
            a_out_ready = 1'($urandom_range(1, 0));
        end
        chk("rnd_accepted", accepted, NW);
        chk("rnd_popped", popped, NW);
        chk("rnd_leftover", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
